// File: rtl/alu_pipe_unit.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, flags and an accumulator mode.
// Define ALU_PIPE_MUL_EN to build opcode 7 as an iterative shift-add multiplier.
module alu_pipe_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       sel,
    input  logic             cin,
    input  logic             acc_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL_RUN, HOLD} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, zero_q, negative_q, overflow_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] result_d;
    logic             carry_d, overflow_d;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [SW-1:0]    shamt;
    logic             accept;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = rst_n & ena & (state_q != MUL_RUN) & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;

    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign overflow = overflow_q;

    // Shifts are done one bit wider so the last bit shifted out lands in the spare bit.
    always_comb begin
        a_d        = acc_mode ? acc_q : op_a;
        shamt      = op_b[SW-1:0];
        add_w      = {1'b0, a_d} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        sub_w      = {1'b0, a_d} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        shl_w      = {1'b0, a_d} << shamt;
        shr_w      = {a_d, 1'b0} >> shamt;
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (sel)
            3'd0: begin
                result_d   = add_w[WIDTH-1:0];
                carry_d    = add_w[WIDTH];
                overflow_d = (a_d[WIDTH-1] == op_b[WIDTH-1]) && (add_w[WIDTH-1] != a_d[WIDTH-1]);
            end
            3'd1: begin
                result_d   = sub_w[WIDTH-1:0];
                carry_d    = sub_w[WIDTH];
                overflow_d = (a_d[WIDTH-1] != op_b[WIDTH-1]) && (sub_w[WIDTH-1] != a_d[WIDTH-1]);
            end
            3'd2: result_d = a_d & op_b;
            3'd3: result_d = a_d | op_b;
            3'd4: result_d = a_d ^ op_b;
            3'd5: begin
                result_d = shl_w[WIDTH-1:0];
                carry_d  = shl_w[WIDTH];
            end
            3'd6: begin
                result_d = shr_w[WIDTH:1];
                carry_d  = shr_w[0];
            end
            default: result_d = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, prod_q, prod_next;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    always_comb prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            mcand_q    <= '0;
            prod_q     <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
`endif
        end else if (ena) begin
`ifdef ALU_PIPE_MUL_EN
            if (state_q == MUL_RUN) begin
                prod_q   <= prod_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
                // The final shift-add step and the result write share one edge.
                if (cnt_q == CW'(1)) begin
                    result_q   <= prod_next[WIDTH-1:0];
                    acc_q      <= prod_next[WIDTH-1:0];
                    carry_q    <= |prod_next[2*WIDTH-1:WIDTH];
                    zero_q     <= (prod_next[WIDTH-1:0] == '0);
                    negative_q <= prod_next[WIDTH-1];
                    overflow_q <= 1'b0;
                    state_q    <= HOLD;
                end
            end else if (accept && (sel == 3'd7)) begin
                mcand_q  <= {{WIDTH{1'b0}}, a_d};
                mplier_q <= op_b;
                prod_q   <= '0;
                cnt_q    <= CW'(WIDTH);
                state_q  <= MUL_RUN;
            end else
`endif
            if (accept) begin
                result_q   <= result_d;
                acc_q      <= result_d;
                carry_q    <= carry_d;
                zero_q     <= (result_d == '0);
                negative_q <= result_d[WIDTH-1];
                overflow_q <= overflow_d;
                state_q    <= HOLD;
            end else if ((state_q == HOLD) && out_ready) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: doc/alu_pipe_unit.md
# alu_pipe_unit

Parametrised, registered successor of the demo ALU top: a WIDTH-bit ALU with valid/ready handshakes on input and output, registered flags, an accumulator mode that chains results, and an optional iterative multiplier. It sits between the pin-mapping wrapper (switch inputs, `ena`) and downstream display and LED logic. Single-cycle ops return one cycle after acceptance. Multiply is multi-cycle and backpressures the input.

## Interface
- `WIDTH`, 8: operand and result width. Power of two, ≥4.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: global enable. When 0, all state is frozen and `in_ready` is 0.
- `in_valid` input 1: operation request.
- `in_ready` output 1: operation accepted when `in_valid & in_ready` on a clock edge.
- `op_a` input WIDTH: operand A.
- `op_b` input WIDTH: operand B.
- `sel` input 3: opcode.
- `cin` input 1: carry-in, used by ADD only.
- `acc_mode` input 1: 1 = operand A is replaced by the internal accumulator.
- `out_valid` output 1: result registers hold an undelivered result.
- `out_ready` input 1: consumer accepts the result on `out_valid & out_ready`.
- `result` output WIDTH: registered result.
- `carry`, `zero`, `negative`, `overflow` output 1 each: registered flags.

## Operation
- Opcodes:
  - 0 ADD: A+B+cin.
  - 1 SUB: A+~B+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: A << B[log2(WIDTH)-1:0].
  - 6 SHR (logical): same shift amount.
  - 7 MUL: low WIDTH bits of A*B.
- Carry flag:
  - ADD: carry out.
  - SUB: 1 = no borrow.
  - SHL/SHR: last bit shifted out; 0 for shift of 0.
  - Logic ops: 0.
  - MUL: 1 if the high product half is non-zero.
- Overflow flag: signed overflow for ADD/SUB; 0 for all other ops.
- Zero and negative flags: `result==0` and `result[WIDTH-1]`.
- States: IDLE, MUL_RUN, HOLD.
  - IDLE, accept a single-cycle op: register result and flags, go to HOLD.
  - IDLE, accept MUL: latch A, B, clear partial product, load counter = WIDTH, go to MUL_RUN.
  - MUL_RUN: one shift-add per cycle. When the counter reaches 0, write result and flags, go to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, return to IDLE, or accept a new op in the same cycle (back-to-back).
- `in_ready` = `ena & state!=MUL_RUN & (!out_valid | out_ready)`.
- Accumulator:
  - WIDTH-bit register, reset 0.
  - Loaded with every result at the moment it is written to `result`, regardless of `acc_mode`.
  - When `acc_mode`=1 at acceptance, it replaces `op_a`.
- Operands and `sel` are sampled only at acceptance. Later input changes are ignored.
- Reset values: `result`=0, all flags 0, `out_valid`=0, accumulator 0, state IDLE. `in_ready` is 0 during reset and equals `ena` after release.

## Timing
- Single-cycle op: accepted at edge N, `out_valid` high after edge N+1 (latency 1).
- MUL: accepted at edge N, `out_valid` high after edge N+WIDTH. `in_ready` is low throughout.
- Sustained throughput is one single-cycle op per clock when `out_ready` is held high.
- `result` and flags are stable while `out_valid & !out_ready`.
- `ena`=0 freezes every register, including the MUL counter. Operation resumes exactly where it stopped.
- Asserting reset mid-MUL aborts the multiply immediately. No partial result is ever presented.

## Configuration
- `ALU_PIPE_MUL_EN` defined: opcode 7 is the iterative multiplier described above, and MUL_RUN exists.
- Not defined: no multiplier logic. Opcode 7 completes in one cycle with `result`=0, `zero`=1, all other flags 0, and the accumulator loaded with 0.

## Test plan
- WIDTH=8, ADD 0x7F+0x01, cin=0 -> `result`=0x80, `overflow`=1, `negative`=1, `carry`=0, `out_valid` one cycle after accept.
- SUB 0x05-0x05 -> 0x00, `zero`=1, `carry`=1. Then SUB 0x00-0x01 -> 0xFF, `carry`=0, `negative`=1.
- `out_ready` held low 3 cycles after a result -> `result` held, `in_ready`=0. Raise `out_ready` while a new op is valid -> drain and accept in the same cycle, new result on the next cycle.
- `acc_mode`=1, three back-to-back ADDs with B=3 -> results 3, 6, 9 on consecutive cycles.
- MUL 13*11 -> 0x8F, `carry`=0, `out_valid` 8 cycles after accept. MUL 0x10*0x10 -> 0x00, `carry`=1, `zero`=1.
- Pull `rst_n` low mid-MUL -> all outputs 0 immediately. `ena` low for 2 cycles during MUL -> completion delayed by exactly 2 cycles.
